branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised branch resolution and prediction block for the RV32 pipeline. Execute stage: compares the two source operands itself (signed and unsigned), evaluates all six RV32I branch conditions, and flags mispredictions. Fetch stage: a direct-mapped table of 2-bit saturating counters supplies a taken/not-taken prediction. Saturating event counters record resolved branches and mispredictions for performance debug.

## Interface
Parameters:
- `XLEN`, default 32: operand and PC width.
- `BHT_ENTRIES`, default 64: number of counter entries; power of two, minimum 2.
- `PC_LSB`, default 2: lowest PC bit used for the table index.

Ports:
- `i_clk`, in, 1: clock; all state updates on the rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_f_pc`, in, XLEN: fetch PC.
- `o_f_pred_taken`, out, 1: prediction for `i_f_pc`; combinational.
- `i_x_valid`, in, 1: execute stage holds a valid instruction.
- `i_x_branch`, in, 1: instruction is a conditional branch.
- `i_x_funct3`, in, 3: branch funct3.
- `i_x_op1`, in, XLEN: rs1 value.
- `i_x_op2`, in, XLEN: rs2 value.
- `i_x_pc`, in, XLEN: branch PC.
- `i_x_pred_taken`, in, 1: prediction carried down the pipe with the branch.
- `o_x_taken`, out, 1: resolved direction; combinational.
- `o_x_mispredict`, out, 1: redirect request; combinational.
- `o_x_illegal`, out, 1: branch with funct3 010 or 011; combinational.
- `o_branch_count`, out, 32: resolved-branch count.
- `o_mispredict_count`, out, 32: misprediction count.

## Operation
- Resolve condition, with `res = i_x_valid & i_x_branch`:
  - 000 BEQ: op1 == op2.
  - 001 BNE: op1 != op2.
  - 100 BLT: signed op1 < op2.
  - 101 BGE: signed op1 >= op2.
  - 110 BLTU: unsigned op1 < op2.
  - 111 BGEU: unsigned op1 >= op2.
  - 010 and 011: condition 0.
- Compares use the full XLEN width; signed compares are two's complement.
- `o_x_taken = res & cond`.
- `o_x_illegal = res & (funct3 is 010 or 011)`.
- `o_x_mispredict = res & (o_x_taken != i_x_pred_taken)`. This also applies to illegal funct3, so a predicted-taken illegal branch mispredicts.
- Table index is `pc[PC_LSB +: log2(BHT_ENTRIES)]`, for both fetch and resolve.
- Prediction is the counter's MSB.
- Table update occurs when `res` is set and funct3 is legal. The counter at the `i_x_pc` index increments toward 11 if taken and decrements toward 00 if not, saturating at both ends.
- Illegal-funct3 branches never update the table.
- `o_branch_count` increments on every `res`, including illegal funct3. `o_mispredict_count` increments on every `o_x_mispredict`. Both saturate at 0xFFFFFFFF.

## Timing
- Reset: every table counter = 01 (weakly not-taken), both event counters = 0. At reset, `o_f_pred_taken` = 0 for every PC. The combinational outputs follow their inputs.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. No update is taken on the edge where `i_rst_n` is low.
- Prediction and resolve outputs have zero latency (combinational).
- Table and counter updates become visible the cycle after the resolving edge.
- Same-cycle fetch read and resolve write to the same index: fetch sees the old value; there is no bypass.
- Aliasing: PCs that differ only above the index bits share an entry. No tag check.
- A branch with `i_x_valid`=0 or `i_x_branch`=0 causes no state change, and all three execute outputs are 0.

## Configuration
- `BRANCH_PREDICT_EN` defined: the table is built and predictions operate as above.
- `BRANCH_PREDICT_EN` undefined:
  - No table storage is built.
  - `o_f_pred_taken` is tied to 0.
  - `i_x_pc` is unused.
  - The resolve logic, `o_x_mispredict` (effectively equal to `o_x_taken` when the pipe feeds back pred=0) and both event counters are unchanged.

## Test plan
- Reset, then sweep `i_f_pc` over all indices → `o_f_pred_taken`=0 everywhere; both counts 0.
- Taken BEQ with op1=op2=5 at PC 0x100, pred=0 → `o_x_taken`=1 and `o_x_mispredict`=1. The next cycle, `o_f_pred_taken`=1 at 0x100 (counter 10) and at its alias 0x200 (default parameters); `o_mispredict_count`=1.
- Saturation: three further taken BEQs at 0x100, then one not-taken → counter goes 11 then 10, and the prediction stays 1. Two more not-taken → counter 00, prediction 0; a further not-taken keeps it at 00.
- op1=0xFFFFFFFF, op2=1 → BLT taken, BGE not, BLTU not, BGEU taken. funct3=010 → taken=0, illegal=1, no table change, `o_branch_count` increments.
- Same-cycle read/write: fetch 0x100 while resolving a taken branch at 0x100 from counter 01 → fetch sees 0 that cycle and 1 the next.
- Pulse `i_rst_n` low between clock edges after training → predictions return to 0 and counts to 0 immediately. With `BRANCH_PREDICT_EN` undefined, repeat the training scenario → the prediction stays 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// Execute-stage branch resolution for RV32 (all six RV32I conditions, with the
// operand compares done locally), misprediction flagging, saturating event
// counters, and an optional direct-mapped table of 2-bit saturating counters
// that supplies the fetch-stage prediction.
// Optional feature macro: BRANCH_PREDICT_EN (builds the prediction table;
// when undefined the prediction is tied to not-taken).
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int PC_LSB      = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_f_pc,
    output logic            o_f_pred_taken,
    input  logic            i_x_valid,
    input  logic            i_x_branch,
    input  logic [2:0]      i_x_funct3,
    input  logic [XLEN-1:0] i_x_op1,
    input  logic [XLEN-1:0] i_x_op2,
    input  logic [XLEN-1:0] i_x_pc,
    input  logic            i_x_pred_taken,
    output logic            o_x_taken,
    output logic            o_x_mispredict,
    output logic            o_x_illegal,
    output logic [31:0]     o_branch_count,
    output logic [31:0]     o_mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic signed [XLEN-1:0] op1_s;
    logic signed [XLEN-1:0] op2_s;
    logic                   eq;
    logic                   lt_s;
    logic                   lt_u;
    logic                   cond;
    logic                   legal;
    logic                   res;

    assign op1_s = i_x_op1;
    assign op2_s = i_x_op2;
    assign eq    = (i_x_op1 == i_x_op2);
    assign lt_s  = (op1_s < op2_s);
    assign lt_u  = (i_x_op1 < i_x_op2);
    assign res   = i_x_valid & i_x_branch;

    // Branch condition decode; 010/011 are reserved and never taken.
    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (i_x_funct3)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = lt_s;
            3'b101:  cond = ~lt_s;
            3'b110:  cond = lt_u;
            3'b111:  cond = ~lt_u;
            default: begin
                cond  = 1'b0;
                legal = 1'b0;
            end
        endcase
    end

    assign o_x_taken      = res & cond;
    assign o_x_illegal    = res & ~legal;
    assign o_x_mispredict = res & (o_x_taken != i_x_pred_taken);

    // Performance counters: every resolved branch and every redirect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_branch_count     <= 32'd0;
            o_mispredict_count <= 32'd0;
        end else begin
            if (res) begin
                o_branch_count <= sat_inc32(o_branch_count);
            end
            if (o_x_mispredict) begin
                o_mispredict_count <= sat_inc32(o_mispredict_count);
            end
        end
    end

`ifdef BRANCH_PREDICT_EN
    // 2-bit counter step toward strongly taken (11) or strongly not-taken (00).
    function automatic logic [1:0] bht_step(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'b11) ? c : c + 2'd1;
        end
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] x_idx;

    // No tag: PCs differing only above the index bits share an entry.
    assign f_idx          = i_f_pc[PC_LSB +: IDX_W];
    assign x_idx          = i_x_pc[PC_LSB +: IDX_W];
    assign o_f_pred_taken = bht[f_idx][1];

    // Table training; fetch reads the pre-update value (no bypass).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (res && legal) begin
            bht[x_idx] <= bht_step(bht[x_idx], cond);
        end
    end
`else
    assign o_f_pred_taken = 1'b0;
`endif

    // PC bits outside the index (or all of them without a table) are don't-care.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_f_pc, i_x_pc};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit (default parameters).
// Works with or without BRANCH_PREDICT_EN defined.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic        x_valid;
    logic        x_branch;
    logic [2:0]  x_funct3;
    logic [31:0] x_op1;
    logic [31:0] x_op2;
    logic [31:0] x_pc;
    logic        x_pred_taken;
    logic        x_taken;
    logic        x_mispredict;
    logic        x_illegal;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_predict_unit dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_f_pc             (f_pc),
        .o_f_pred_taken     (f_pred_taken),
        .i_x_valid          (x_valid),
        .i_x_branch         (x_branch),
        .i_x_funct3         (x_funct3),
        .i_x_op1            (x_op1),
        .i_x_op2            (x_op2),
        .i_x_pc             (x_pc),
        .i_x_pred_taken     (x_pred_taken),
        .o_x_taken          (x_taken),
        .o_x_mispredict     (x_mispredict),
        .o_x_illegal        (x_illegal),
        .o_branch_count     (branch_count),
        .o_mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        branch;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic        pred;
        logic        e_taken;
        logic        e_mis;
        logic        e_ill;
    } vec_t;

    typedef struct {
        logic taken;
        logic mis;
        logic ill;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[16];
    logic [1:0]  mbht[64];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic vec_t mk(input logic v, input logic br, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic pred,
                                input logic et, input logic em, input logic ei);
        vec_t r;
        r.valid = v; r.branch = br; r.f3 = f3; r.a = a; r.b = b; r.pc = pc;
        r.pred = pred; r.e_taken = et; r.e_mis = em; r.e_ill = ei;
        return r;
    endfunction

    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd63);
    endfunction

    function automatic logic m_pred(input logic [31:0] pc);
`ifdef BRANCH_PREDICT_EN
        return mbht[idx_of(pc)][1];
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mbht[i] = 2'b01;
        m_bcnt = 32'd0;
        m_mcnt = 32'd0;
    endtask

    task automatic idle();
        x_valid = 1'b0; x_branch = 1'b0; x_funct3 = 3'b000;
        x_op1 = 32'd0; x_op2 = 32'd0; x_pc = 32'd0; x_pred_taken = 1'b0;
    endtask

    // Drive one execute-stage instruction, check outputs and the same-cycle
    // fetch prediction, then advance the reference model for the coming edge.
    task automatic drive_x(input vec_t v, input string name);
        exp_t e;
        exp_t g;
        @(negedge clk);
        x_valid = v.valid; x_branch = v.branch; x_funct3 = v.f3;
        x_op1 = v.a; x_op2 = v.b; x_pc = v.pc; x_pred_taken = v.pred;
        e.taken = v.e_taken; e.mis = v.e_mis; e.ill = v.e_ill;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        check({name, ".taken"}, {31'd0, x_taken}, {31'd0, g.taken});
        check({name, ".mispredict"}, {31'd0, x_mispredict}, {31'd0, g.mis});
        check({name, ".illegal"}, {31'd0, x_illegal}, {31'd0, g.ill});
        check({name, ".fetch_pred"}, {31'd0, f_pred_taken}, {31'd0, m_pred(f_pc)});
        if (v.valid && v.branch) begin
            if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
            if (v.e_mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
            if (!v.e_ill) begin
                if (v.e_taken && mbht[idx_of(v.pc)] != 2'b11)
                    mbht[idx_of(v.pc)] = mbht[idx_of(v.pc)] + 2'd1;
                else if (!v.e_taken && mbht[idx_of(v.pc)] != 2'b00)
                    mbht[idx_of(v.pc)] = mbht[idx_of(v.pc)] - 2'd1;
            end
        end
    endtask

    // Hand-sequence branch: expected values from the reference condition.
    task automatic branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic pred, input string name);
        logic t;
        logic ill;
        t   = ref_cond(f3, a, b);
        ill = (f3 == 3'b010) || (f3 == 3'b011);
        drive_x(mk(1'b1, 1'b1, f3, a, b, pc, pred, t, t != pred, ill), name);
    endtask

    task automatic check_pred(input logic [31:0] pc, input string name);
        @(negedge clk);
        idle();
        f_pc = pc;
        #1;
        check(name, {31'd0, f_pred_taken}, {31'd0, m_pred(pc)});
    endtask

    task automatic check_counts(input string name);
        @(negedge clk);
        idle();
        #1;
        check({name, ".branch_count"}, branch_count, m_bcnt);
        check({name, ".mispredict_count"}, mispredict_count, m_mcnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1, 1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 1, 1, 0, 0);
        vecs[1]  = mk(1, 1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h44, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h48, 1, 0, 1, 0);
        vecs[3]  = mk(1, 1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h4C, 0, 1, 1, 0);
        vecs[4]  = mk(1, 1, 3'b010, 32'd5, 32'd5, 32'h50, 0, 0, 0, 1);
        vecs[5]  = mk(1, 1, 3'b011, 32'd5, 32'd5, 32'h54, 1, 0, 1, 1);
        vecs[6]  = mk(1, 1, 3'b000, 32'd7, 32'd8, 32'h58, 0, 0, 0, 0);
        vecs[7]  = mk(1, 1, 3'b001, 32'd7, 32'd8, 32'h5C, 0, 1, 1, 0);
        vecs[8]  = mk(1, 1, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h60, 0, 1, 1, 0);
        vecs[9]  = mk(1, 1, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 32'h64, 0, 0, 0, 0);
        vecs[10] = mk(1, 1, 3'b101, 32'd3, 32'd3, 32'h68, 1, 1, 0, 0);
        vecs[11] = mk(1, 1, 3'b111, 32'd3, 32'd3, 32'h6C, 1, 1, 0, 0);
        vecs[12] = mk(1, 1, 3'b100, 32'd3, 32'd3, 32'h70, 1, 0, 1, 0);
        vecs[13] = mk(0, 1, 3'b000, 32'd5, 32'd5, 32'h74, 1, 0, 0, 0);
        vecs[14] = mk(1, 0, 3'b000, 32'd5, 32'd5, 32'h78, 1, 0, 0, 0);
        vecs[15] = mk(1, 1, 3'b001, 32'd5, 32'd5, 32'h7C, 1, 0, 1, 0);

        model_reset();
        idle();
        f_pc  = 32'd0;
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state across every index (upper bits set to exercise aliasing).
        for (int i = 0; i < 64; i++) begin
            f_pc = (i << 2) | 32'hA000_0000;
            #1;
            check($sformatf("reset.pred[%0d]", i), {31'd0, f_pred_taken}, 32'd0);
        end
        check_counts("reset");

        // First taken BEQ at 0x100, predicted not-taken, fetch on the same PC.
        f_pc = 32'h100;
        branch(3'b000, 32'd5, 32'd5, 32'h100, 1'b0, "beq_first");
        check_pred(32'h100, "train.pred_0x100");
        check_pred(32'h200, "train.pred_alias_0x200");
        check_counts("train");
        check("train.mispredict_count_is_1", mispredict_count, 32'd1);

        // Saturation up then down, and the floor at 00.
        for (int k = 0; k < 3; k++) branch(3'b000, 32'd5, 32'd5, 32'h100, m_pred(32'h100), "beq_up");
        branch(3'b000, 32'd5, 32'd6, 32'h100, m_pred(32'h100), "beq_dn1");
        check_pred(32'h100, "sat.after_11_to_10");
        for (int k = 0; k < 2; k++) branch(3'b000, 32'd5, 32'd6, 32'h100, m_pred(32'h100), "beq_dn");
        check_pred(32'h100, "sat.at_00");
        branch(3'b000, 32'd5, 32'd6, 32'h100, 1'b0, "beq_dn_floor");
        branch(3'b000, 32'd5, 32'd5, 32'h100, 1'b0, "beq_up_from_00");
        check_pred(32'h100, "sat.floor_held");
        check_counts("sat");

        // Condition table, including reserved funct3 and gated-off cases.
        for (int i = 0; i < 16; i++) begin
            f_pc = vecs[i].pc;
            drive_x(vecs[i], $sformatf("vec%0d", i));
        end
        check_counts("vectors");
        check_pred(32'h50, "illegal.no_table_change");
        check_pred(32'h74, "invalid.no_table_change");
        check_pred(32'h4C, "bgeu.trained");

        // Train 0x104 then pulse reset between edges.
        branch(3'b000, 32'd1, 32'd1, 32'h104, 1'b0, "pre_rst1");
        branch(3'b000, 32'd1, 32'd1, 32'h104, m_pred(32'h104), "pre_rst2");
        check_pred(32'h104, "pre_rst.pred");
        @(negedge clk);
        f_pc = 32'h104;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst.pred", {31'd0, f_pred_taken}, 32'd0);
        check("async_rst.branch_count", branch_count, 32'd0);
        check("async_rst.mispredict_count", mispredict_count, 32'd0);
        x_valid = 1'b1; x_branch = 1'b1; x_funct3 = 3'b000;
        x_op1 = 32'd9; x_op2 = 32'd9; x_pc = 32'h104; x_pred_taken = 1'b0;
        @(posedge clk);
        #1;
        check("rst_edge.branch_count", branch_count, 32'd0);
        check("rst_edge.pred", {31'd0, f_pred_taken}, 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // Same-cycle fetch/resolve to one index: old value, then new.
        f_pc = 32'h100;
        branch(3'b000, 32'd2, 32'd2, 32'h100, 1'b0, "same_cycle");
        check_pred(32'h100, "same_cycle.next");
        check_counts("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
